// File: rtl/opn2_bus_pkg.sv
// Shared types and helpers for the YM3438 CPU-bus initiator.
package opn2_bus_pkg;

  typedef enum logic [2:0] {
    RESET_IC = 3'd0,
    IDLE     = 3'd1,
    POLL     = 3'd2,
    ADDR_WR  = 3'd3,
    DATA_WR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SETUP   = 2'd0,
    STROBE  = 2'd1,
    HOLD    = 2'd2,
    RECOVER = 2'd3
  } phase_t;

  // Status byte bit that reports the chip is still busy.
  localparam int BUSY_BIT = 7;

  // Low address bit: register-address port vs register-data port.
  localparam logic ADDR_LO = 1'b0;
  localparam logic DATA_LO = 1'b1;

  // Everything the block drives onto the chip bus except ic_n.
  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic [1:0] addr;
    logic [7:0] data_o;
    logic       data_oe;
  } bus_pins_t;

  localparam bus_pins_t PINS_IDLE = '{
    cs_n:    1'b1,
    wr_n:    1'b1,
    rd_n:    1'b1,
    addr:    2'd0,
    data_o:  8'h00,
    data_oe: 1'b0
  };

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bus pin values for a given transaction state and phase. Reads never
  // drive the data bus, and only the STROBE phase pulls a strobe low, so
  // rd_n/wr_n and data_oe/rd_n can never collide.
  function automatic bus_pins_t bus_pins(input state_t     st,
                                         input phase_t     ph,
                                         input logic       part,
                                         input logic [7:0] reg_addr,
                                         input logic [7:0] reg_val);
    bus_pins_t p;
    p = PINS_IDLE;
    case (st)
      POLL, ADDR_WR, DATA_WR: begin
        p.cs_n    = (ph == RECOVER);
        p.wr_n    = !((st != POLL) && (ph == STROBE));
        p.rd_n    = !((st == POLL) && (ph == STROBE));
        p.data_oe = (st != POLL) && (ph != RECOVER);
        if (st == POLL) begin
          p.addr   = 2'd0;
          p.data_o = 8'h00;
        end else if (st == ADDR_WR) begin
          p.addr   = {part, ADDR_LO};
          p.data_o = reg_addr;
        end else begin
          p.addr   = {part, DATA_LO};
          p.data_o = reg_val;
        end
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/opn2_bus_timer.sv
// Loadable down-counter shared by the IC pulse and the bus phase timing.
// A load of N makes done rise on the N-th cycle after the load edge.
module opn2_bus_timer #(
  parameter int W           = 8,
  parameter int RESET_COUNT = 192
) (
  input  logic         MCLK,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Count down to zero and park there; reset arms the IC pulse length.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      count <= W'(RESET_COUNT);
    end else if (load) begin
      count <= load_val - W'(1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/opn2_bus_master.sv
// Host-side initiator for the YM3438 CPU bus: IC pulse after reset, then
// queued register writes as address/data cycle pairs, optionally preceded
// by status polls until the busy flag clears.
module opn2_bus_master
  import opn2_bus_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_STROBE  = 12,
  parameter int T_HOLD    = 2,
  parameter int T_RECOVER = 6,
  parameter int IC_CYCLES = 192,
  parameter bit POLL_EN   = 1'b1,
  parameter int POLL_MAX  = 1024
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_part,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_data,
  output logic       ic_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [1:0] addr,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i,
  output logic       busy,
  output logic [7:0] status_q,
  output logic       timeout_flag
);

  localparam int TMAX = max_int(max_int(max_int(T_SETUP, T_STROBE),
                                        max_int(T_HOLD, T_RECOVER)),
                                IC_CYCLES);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PCW  = $clog2(POLL_MAX + 1);

  state_t          state_r, state_nx;
  phase_t          phase_r, phase_nx;
  logic            pending_r, pending_nx;
  logic            part_r, part_nx;
  logic [7:0]      reg_r, reg_nx;
  logic [7:0]      data_r, data_nx;
  logic [PCW-1:0]  poll_cnt_r, poll_cnt_nx;
  logic            timeout_nx;
  logic [7:0]      status_nx;
  logic            ready_nx;
  logic            accept;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_done;
  bus_pins_t       pins_r;

  opn2_bus_timer #(
    .W           (TW),
    .RESET_COUNT (IC_CYCLES)
  ) u_timer (
    .MCLK     (MCLK),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state decisions. A newly accepted request first spends one cycle
  // in a pending RECOVER so SETUP starts on the cycle after acceptance;
  // consecutive transactions chain RECOVER straight into the next SETUP.
  always_comb begin
    state_nx    = state_r;
    phase_nx    = phase_r;
    pending_nx  = pending_r;
    part_nx     = part_r;
    reg_nx      = reg_r;
    data_nx     = data_r;
    poll_cnt_nx = poll_cnt_r;
    timeout_nx  = timeout_flag;
    status_nx   = status_q;
    ready_nx    = 1'b0;
    accept      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    case (state_r)
      RESET_IC: begin
        if (tmr_done) begin
          state_nx = IDLE;
        end else begin
          state_nx = RESET_IC;
        end
      end
      IDLE: begin
        accept = req_valid && req_ready;
        if (accept) begin
          part_nx     = req_part;
          reg_nx      = req_reg;
          data_nx     = req_data;
          poll_cnt_nx = '0;
          pending_nx  = 1'b1;
          phase_nx    = RECOVER;
          tmr_load    = 1'b1;
          tmr_val     = TW'(1);
          state_nx    = POLL_EN ? POLL : ADDR_WR;
        end else begin
          ready_nx = 1'b1;
        end
      end
      POLL, ADDR_WR, DATA_WR: begin
        if (tmr_done) begin
          case (phase_r)
            SETUP: begin
              phase_nx = STROBE;
              tmr_load = 1'b1;
              tmr_val  = TW'(T_STROBE);
            end
            STROBE: begin
              phase_nx = HOLD;
              tmr_load = 1'b1;
              tmr_val  = TW'(T_HOLD);
              if (state_r == POLL) begin
                status_nx = data_i;
              end else begin
                status_nx = status_q;
              end
            end
            HOLD: begin
              phase_nx = RECOVER;
              tmr_load = 1'b1;
              tmr_val  = TW'(T_RECOVER);
            end
            RECOVER: begin
              phase_nx   = SETUP;
              pending_nx = 1'b0;
              tmr_load   = 1'b1;
              tmr_val    = TW'(T_SETUP);
              if (pending_r) begin
                state_nx = state_r;
              end else begin
                case (state_r)
                  POLL: begin
                    if (!status_q[BUSY_BIT]) begin
                      state_nx = ADDR_WR;
                    end else if (poll_cnt_r + PCW'(1) == PCW'(POLL_MAX)) begin
                      state_nx   = ADDR_WR;
                      timeout_nx = 1'b1;
                    end else begin
                      state_nx    = POLL;
                      poll_cnt_nx = poll_cnt_r + PCW'(1);
                    end
                  end
                  ADDR_WR: state_nx = DATA_WR;
                  DATA_WR: begin
                    state_nx = IDLE;
                    tmr_load = 1'b0;
                    ready_nx = 1'b1;
                  end
                  default: state_nx = state_r;
                endcase
              end
            end
            default: phase_nx = phase_r;
          endcase
        end else begin
          phase_nx = phase_r;
        end
      end
      default: state_nx = RESET_IC;
    endcase
  end

  // State and registered outputs; reset restarts the IC pulse from scratch.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_r      <= RESET_IC;
      phase_r      <= SETUP;
      pending_r    <= 1'b0;
      part_r       <= 1'b0;
      reg_r        <= 8'h00;
      data_r       <= 8'h00;
      poll_cnt_r   <= '0;
      pins_r       <= PINS_IDLE;
      ic_n         <= 1'b0;
      req_ready    <= 1'b0;
      busy         <= 1'b1;
      status_q     <= 8'h00;
      timeout_flag <= 1'b0;
    end else begin
      state_r      <= state_nx;
      phase_r      <= phase_nx;
      pending_r    <= pending_nx;
      part_r       <= part_nx;
      reg_r        <= reg_nx;
      data_r       <= data_nx;
      poll_cnt_r   <= poll_cnt_nx;
      pins_r       <= bus_pins(state_nx, phase_nx, part_nx, reg_nx, data_nx);
      ic_n         <= (state_nx != RESET_IC);
      req_ready    <= ready_nx;
      busy         <= (state_nx != IDLE);
      status_q     <= status_nx;
      timeout_flag <= timeout_nx;
    end
  end

  assign cs_n    = pins_r.cs_n;
  assign wr_n    = pins_r.wr_n;
  assign rd_n    = pins_r.rd_n;
  assign addr    = pins_r.addr;
  assign data_o  = pins_r.data_o;
  assign data_oe = pins_r.data_oe;

endmodule

// File: tb/tb_opn2_bus_master.sv
// Directed bench: dut_a runs without polling, dut_b polls with POLL_MAX=4.
// Both share the request inputs; a small status model feeds dut_b reads.
module tb_opn2_bus_master;

  typedef logic [191:0] vec_t;
  localparam int TRACE_LEN = 150;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic       reset     = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_part  = 1'b0;
  logic [7:0] req_reg   = 8'h00;
  logic [7:0] req_data  = 8'h00;
  logic [7:0] data_i;

  logic       a_req_ready, a_ic_n, a_cs_n, a_wr_n, a_rd_n, a_data_oe, a_busy, a_timeout;
  logic [1:0] a_addr;
  logic [7:0] a_data_o, a_status;
  logic       b_req_ready, b_ic_n, b_cs_n, b_wr_n, b_rd_n, b_data_oe, b_busy, b_timeout;
  logic [1:0] b_addr;
  logic [7:0] b_data_o, b_status;

  opn2_bus_master #(.POLL_EN(1'b0)) dut_a (
    .MCLK(MCLK), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_part(req_part), .req_reg(req_reg), .req_data(req_data), .ic_n(a_ic_n),
    .cs_n(a_cs_n), .wr_n(a_wr_n), .rd_n(a_rd_n), .addr(a_addr), .data_o(a_data_o),
    .data_oe(a_data_oe), .data_i(data_i), .busy(a_busy), .status_q(a_status),
    .timeout_flag(a_timeout)
  );

  opn2_bus_master #(.POLL_EN(1'b1), .POLL_MAX(4)) dut_b (
    .MCLK(MCLK), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_part(req_part), .req_reg(req_reg), .req_data(req_data), .ic_n(b_ic_n),
    .cs_n(b_cs_n), .wr_n(b_wr_n), .rd_n(b_rd_n), .addr(b_addr), .data_o(b_data_o),
    .data_oe(b_data_oe), .data_i(data_i), .busy(b_busy), .status_q(b_status),
    .timeout_flag(b_timeout)
  );

  // Status model: the first busy_reads reads of a request return busy.
  int   busy_reads = 0;
  int   read_base  = 0;
  int   reads_seen = 0;
  logic b_rd_prev  = 1'b1;
  assign data_i = ((reads_seen - read_base) <= busy_reads) ? 8'h80 : 8'h00;

  // Count each new rd_n low pulse from dut_b.
  always @(negedge MCLK) begin
    b_rd_prev <= b_rd_n;
    if (b_rd_prev === 1'b1 && b_rd_n === 1'b0) reads_seen <= reads_seen + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  vec_t a_cs, a_wr, a_rd, a_oe, a_rdy, b_cs, b_wr, b_rd, b_oe, b_rdy;
  logic [1:0] a_addr_h [0:TRACE_LEN];
  logic [7:0] a_do_h   [0:TRACE_LEN];
  logic [1:0] b_addr_h [0:TRACE_LEN];
  logic [7:0] b_do_h   [0:TRACE_LEN];

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic vec_t mask(input int lo, input int hi);
    vec_t m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Wait for both blocks ready, present one request for one cycle.
  task automatic start_request(input logic part, input logic [7:0] rv, input logic [7:0] dv);
    int waited;
    waited = 0;
    while (!(a_req_ready === 1'b1 && b_req_ready === 1'b1) && waited < 400) begin
      @(negedge MCLK);
      waited++;
    end
    check("ready_wait", vec_t'(a_req_ready === 1'b1 && b_req_ready === 1'b1), vec_t'(1'b1));
    read_base = reads_seen;
    req_valid = 1'b1;
    req_part  = part;
    req_reg   = rv;
    req_data  = dv;
    @(negedge MCLK);
    req_valid = 1'b0;
    check("ready_drop", vec_t'({a_req_ready, b_req_ready}), vec_t'(2'b00));
  endtask

  // Bit k of each trace = pin active in the cycle after edge N+k.
  task automatic trace();
    a_cs = '0; a_wr = '0; a_rd = '0; a_oe = '0; a_rdy = '0;
    b_cs = '0; b_wr = '0; b_rd = '0; b_oe = '0; b_rdy = '0;
    for (int k = 1; k <= TRACE_LEN; k++) begin
      @(negedge MCLK);
      a_cs[k] = !a_cs_n; a_wr[k] = !a_wr_n; a_rd[k] = !a_rd_n;
      a_oe[k] = a_data_oe; a_rdy[k] = a_req_ready;
      b_cs[k] = !b_cs_n; b_wr[k] = !b_wr_n; b_rd[k] = !b_rd_n;
      b_oe[k] = b_data_oe; b_rdy[k] = b_req_ready;
      a_addr_h[k] = a_addr; a_do_h[k] = a_data_o;
      b_addr_h[k] = b_addr; b_do_h[k] = b_data_o;
    end
  endtask

  // Hand timeline: each bus cycle is 2 setup + 12 strobe + 2 hold + 6 recover.
  task automatic check_request(input logic part, input logic [7:0] rv, input logic [7:0] dv,
                               input int reads, input logic [7:0] st_exp, input logic to_exp);
    vec_t e_cs, e_rd;
    int   off;
    off = 22 * reads;
    check("a_cs_n",    a_cs,  mask(1, 16) | mask(23, 38));
    check("a_wr_n",    a_wr,  mask(3, 14) | mask(25, 36));
    check("a_rd_n",    a_rd,  vec_t'(0));
    check("a_data_oe", a_oe,  mask(1, 16) | mask(23, 38));
    check("a_ready",   a_rdy, mask(45, TRACE_LEN));
    check("a_addr_lo", vec_t'(a_addr_h[3]),  vec_t'({part, 1'b0}));
    check("a_data_lo", vec_t'(a_do_h[3]),    vec_t'(rv));
    check("a_addr_hi", vec_t'(a_addr_h[36]), vec_t'({part, 1'b1}));
    check("a_data_hi", vec_t'(a_do_h[36]),   vec_t'(dv));
    e_cs = mask(off + 1, off + 16) | mask(off + 23, off + 38);
    e_rd = '0;
    for (int i = 0; i < reads; i++) begin
      e_cs = e_cs | mask(1 + 22 * i, 16 + 22 * i);
      e_rd = e_rd | mask(3 + 22 * i, 14 + 22 * i);
    end
    check("b_cs_n",    b_cs,  e_cs);
    check("b_wr_n",    b_wr,  mask(off + 3, off + 14) | mask(off + 25, off + 36));
    check("b_rd_n",    b_rd,  e_rd);
    check("b_data_oe", b_oe,  mask(off + 1, off + 16) | mask(off + 23, off + 38));
    check("b_ready",   b_rdy, mask(off + 45, TRACE_LEN));
    check("b_poll_addr", vec_t'(b_addr_h[3]),       vec_t'(2'd0));
    check("b_addr_lo",   vec_t'(b_addr_h[off + 3]),  vec_t'({part, 1'b0}));
    check("b_data_lo",   vec_t'(b_do_h[off + 3]),    vec_t'(rv));
    check("b_addr_hi",   vec_t'(b_addr_h[off + 36]), vec_t'({part, 1'b1}));
    check("b_data_hi",   vec_t'(b_do_h[off + 36]),   vec_t'(dv));
    check("b_status",    vec_t'(b_status),  vec_t'(st_exp));
    check("b_timeout",   vec_t'(b_timeout), vec_t'(to_exp));
  endtask

  // After reset release: ic_n low for 192 cycles, bus quiet, ready one cycle later.
  task automatic wait_ic();
    int low;
    int bad;
    low = 0;
    bad = 0;
    @(negedge MCLK);
    while (a_ic_n === 1'b0 && low < 400) begin
      low++;
      if (a_cs_n !== 1'b1 || a_req_ready !== 1'b0) bad++;
      @(negedge MCLK);
    end
    check("ic_len",        vec_t'(low), vec_t'(192));
    check("ic_quiet",      vec_t'(bad), vec_t'(0));
    check("ic_rise_ready", vec_t'(a_req_ready), vec_t'(1'b0));
    @(negedge MCLK);
    check("ready_after_ic", vec_t'({a_req_ready, b_req_ready}), vec_t'(2'b11));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge MCLK);
    check("rst_a", vec_t'({a_ic_n, a_cs_n, a_wr_n, a_rd_n, a_data_oe, a_addr, a_data_o,
                           a_req_ready, a_busy, a_status, a_timeout}),
          vec_t'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}));
    check("rst_b", vec_t'({b_ic_n, b_cs_n, b_wr_n, b_rd_n, b_data_oe, b_addr, b_data_o,
                           b_req_ready, b_busy, b_status, b_timeout}),
          vec_t'({1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0}));
    reset = 1'b0;
    wait_ic();

    busy_reads = 0;
    start_request(1'b0, 8'h28, 8'hF0);
    trace();
    check_request(1'b0, 8'h28, 8'hF0, 1, 8'h00, 1'b0);

    busy_reads = 0;
    start_request(1'b1, 8'hB4, 8'hC0);
    trace();
    check_request(1'b1, 8'hB4, 8'hC0, 1, 8'h00, 1'b0);

    busy_reads = 3;
    start_request(1'b0, 8'h30, 8'h71);
    trace();
    check_request(1'b0, 8'h30, 8'h71, 4, 8'h00, 1'b0);

    busy_reads = 1000;
    start_request(1'b1, 8'hA4, 8'h22);
    trace();
    check_request(1'b1, 8'hA4, 8'h22, 4, 8'h80, 1'b1);

    // Reset lands during dut_a's data-write strobe, request held high.
    busy_reads = 0;
    start_request(1'b0, 8'h2B, 8'h80);
    repeat (29) @(negedge MCLK);
    check("pre_rst_wr", vec_t'(a_wr_n), vec_t'(1'b0));
    reset     = 1'b1;
    req_valid = 1'b1;
    @(negedge MCLK);
    check("rst_mid_a", vec_t'({a_wr_n, a_cs_n, a_data_oe, a_ic_n, a_req_ready}),
          vec_t'(5'b11000));
    check("rst_mid_b", vec_t'({b_rd_n, b_cs_n, b_ic_n, b_timeout}), vec_t'(4'b1100));
    reset = 1'b0;
    wait_ic();
    @(negedge MCLK);
    check("held_accept", vec_t'(a_req_ready), vec_t'(1'b0));
    req_valid = 1'b0;
    @(negedge MCLK);
    check("held_first_cs", vec_t'(a_cs_n), vec_t'(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
